// File: rtl/rr_grant_scheduler_pkg.sv
// Shared constants, state type and rotate-priority search for rr_grant_scheduler.
package rr_grant_scheduler_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Returns {found, idx}: first set request at or after ptr+1, wrapping, so ptr itself is checked last.
    function automatic logic [IDX_W:0] next_rr(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ptr + k[IDX_W-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; output is all zero when en is low.
module dec3to8 (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        if (en) y[sel] = 1'b1;
    end

endmodule

// File: rtl/rr_grant_scheduler_pick8.sv
// rr_pick8: combinational round-robin search over 8 requests starting after ptr.
module rr_pick8
    import rr_grant_scheduler_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        {found, idx} = next_rr(req, ptr);
    end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin owner scheduler for an 8-way shared resource.
// Optional forced release after MAX_HOLD cycles when GRANT_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no owner; grant the first requester found after ptr
// BUSY  | gnt_idx owns the resource until done, request drop or timeout
module rr_grant_scheduler #(
    parameter int N_REQ = 8
`ifdef GRANT_TIMEOUT_EN
    , parameter int MAX_HOLD = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       gnt_idx,
    output logic             gnt_valid
`ifdef GRANT_TIMEOUT_EN
    , output logic           timeout
`endif
);

    import rr_grant_scheduler_pkg::*;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] search_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             norm_release;
    logic             forced_release;
    logic             any_release;

    // In BUSY the search base is the owner itself, which equals the ptr value written on release.
    assign search_ptr   = (state == BUSY) ? gnt_idx : ptr;
    assign norm_release = (state == BUSY) && (done || !req[gnt_idx]);
    assign any_release  = norm_release || forced_release;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (search_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef GRANT_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       new_grant;

    assign forced_release = (state == BUSY) && !norm_release
                            && (hold_cnt == 8'(MAX_HOLD - 1));
    assign new_grant      = pick_found && ((state == IDLE) || any_release);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 8'h00;
            timeout  <= 1'b0;
        end else begin
            timeout <= forced_release;
            if (new_grant)
                hold_cnt <= 8'h00;
            else if (state == BUSY)
                hold_cnt <= hold_cnt + 8'h01;
        end
    end
`else
    assign forced_release = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            ptr       <= 3'd7;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt_idx   <= pick_idx;
                        gnt_valid <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (any_release) begin
                        ptr <= gnt_idx;
                        if (pick_found) begin
                            gnt_idx <= pick_idx;
                        end else begin
                            gnt_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    dec3to8 u_dec (
        .sel (gnt_idx),
        .en  (gnt_valid),
        .y   (gnt)
    );

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed self-checking bench for rr_grant_scheduler (timeout steps only when GRANT_TIMEOUT_EN is defined).
module tb_rr_grant_scheduler;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
`ifdef GRANT_TIMEOUT_EN
    logic       timeout;
`endif

    int checks = 0;
    int errors = 0;

`ifdef GRANT_TIMEOUT_EN
    rr_grant_scheduler #(.N_REQ(8), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );
`else
    rr_grant_scheduler #(.N_REQ(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e_gnt,
                           input logic [2:0] e_idx, input logic e_valid);
        chk({tag, " gnt"}, gnt, e_gnt);
        chk({tag, " gnt_idx"}, {5'b0, gnt_idx}, {5'b0, e_idx});
        chk({tag, " gnt_valid"}, {7'b0, gnt_valid}, {7'b0, e_valid});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        do_reset();
        chk_out("reset", 8'h00, 3'd0, 1'b0);

        // Idle with no requests; a stray done must be ignored.
        for (int i = 0; i < 5; i++) begin
            done = (i == 2);
            step();
            chk_out("idle", 8'h00, 3'd0, 1'b0);
        end
        done = 1'b0;

        // Two requesters, back-to-back handover on done.
        req = 8'h24;
        step();
        chk_out("req24 first", 8'h04, 3'd2, 1'b1);
        done = 1'b1;
        step();
        done = 1'b0;
        chk_out("req24 handover", 8'h20, 3'd5, 1'b1);
        req  = 8'h00;
        done = 1'b1;
        step();
        done = 1'b0;
        chk_out("req24 drain", 8'h00, 3'd5, 1'b0);

        // Full fairness rotation from reset pointer.
        do_reset();
        req = 8'hFF;
        step();
        for (int i = 0; i <= 8; i++) begin
            chk_out("rot grant", 8'h01 << (i % 8), 3'(i % 8), 1'b1);
            step();
            chk_out("rot hold", 8'h01 << (i % 8), 3'(i % 8), 1'b1);
            done = 1'b1;
            step();
            done = 1'b0;
        end
        req = 8'h00;
        step();
        chk_out("rot end", 8'h00, 3'd1, 1'b0);

        // Owner 3 drops request; next search starts at 4 and wraps to 0.
        do_reset();
        req = 8'h08;
        step();
        chk_out("own3", 8'h08, 3'd3, 1'b1);
        step();
        chk_out("own3 hold", 8'h08, 3'd3, 1'b1);
        req = 8'h00;
        step();
        chk_out("own3 drop", 8'h00, 3'd3, 1'b0);
        req = 8'h09;
        step();
        chk_out("wrap to 0", 8'h01, 3'd0, 1'b1);

        // Owner 0 drops; 4 takes over; others must not preempt.
        req = 8'h10;
        step();
        chk_out("own4", 8'h10, 3'd4, 1'b1);
        req = 8'h1F;
        step();
        chk_out("no preempt", 8'h10, 3'd4, 1'b1);
        step();
        chk_out("no preempt 2", 8'h10, 3'd4, 1'b1);

        // Done together with owner request drop is one release: 4 -> 0.
        req  = 8'h09;
        done = 1'b1;
        step();
        done = 1'b0;
        chk_out("done+drop", 8'h01, 3'd0, 1'b1);
        req = 8'h10;
        step();
        chk_out("own4 again", 8'h10, 3'd4, 1'b1);

        // Asynchronous reset mid-grant.
        #2;
        rst_n = 1'b0;
        req   = 8'h11;
        #1;
        chk_out("async rst", 8'h00, 3'd0, 1'b0);
        step();
        #2;
        rst_n = 1'b1;
        step();
        chk_out("post rst", 8'h01, 3'd0, 1'b1);
        done = 1'b1;
        step();
        done = 1'b0;
        chk_out("post rst next", 8'h10, 3'd4, 1'b1);

`ifdef GRANT_TIMEOUT_EN
        // MAX_HOLD=4: owner 0 forced out after 4 BUSY cycles.
        req = 8'h00;
        do_reset();
        req = 8'h03;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("to hold", 8'h01, 3'd0, 1'b1);
            chk("to quiet", {7'b0, timeout}, 8'h00);
        end
        step();
        chk_out("to forced", 8'h02, 3'd1, 1'b1);
        chk("to pulse", {7'b0, timeout}, 8'h01);
        step();
        chk("to pulse end", {7'b0, timeout}, 8'h00);
        chk_out("to after", 8'h02, 3'd1, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
